cumulative_sums_fb: RTL

//  Streaming NIST SP800-22 cumulative-sums test on the PUF/TRNG bit stream. Computes the

---
 rtl/puf_tests_pkg.sv | 15 +
 rtl/cusum_walk.sv | 34 +++
 rtl/cumulative_sums_fb.sv | 75 +++++++
 3 files changed

// File: rtl/puf_tests_pkg.sv
// puf_tests_pkg: shared parameters and helpers for the on-line PUF/TRNG health tests
package puf_tests_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int CS_N = 20000;
  localparam int CS_U = 397;
  localparam int CS_CNT_W = clog2(CS_N);
  localparam int CS_SUM_W = clog2(CS_N + 1) + 1;
  localparam int CS_EXC_W = CS_SUM_W - 1;
  localparam int CS_FAILCNT_W = 8;
endpackage

// File: rtl/cusum_walk.sv
// cusum_walk: +/-1 random walk with running max/min, both seeded at 0 so S_0 is covered
module cusum_walk
  import puf_tests_pkg::*;
#(
  parameter int SUM_W = CS_SUM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_step,
  input  logic                    i_bit,
  output logic signed [SUM_W-1:0] o_s_nxt,
  output logic signed [SUM_W-1:0] o_smax_nxt,
  output logic signed [SUM_W-1:0] o_smin_nxt
);
  localparam logic signed [SUM_W-1:0] ONE = 1;
  logic signed [SUM_W-1:0] r_s, r_smax, r_smin;
  always_comb begin
    o_s_nxt    = i_bit ? r_s + ONE : r_s - ONE;
    o_smax_nxt = (o_s_nxt > r_smax) ? o_s_nxt : r_smax;
    o_smin_nxt = (o_s_nxt < r_smin) ? o_s_nxt : r_smin;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_s    <= '0;
      r_smax <= '0;
      r_smin <= '0;
    end else if (i_step) begin
      r_s    <= o_s_nxt;
      r_smax <= o_smax_nxt;
      r_smin <= o_smin_nxt;
    end
  end
endmodule

// File: rtl/cumulative_sums_fb.sv
// cumulative_sums_fb: streaming forward/backward cumulative-sums test per N-bit block,
// with gap-tolerant input, per-block verdict and block/fail statistics
module cumulative_sums_fb
  import puf_tests_pkg::*;
#(
  parameter int N         = CS_N,
  parameter int U         = CS_U,
  parameter int CNT_W     = CS_CNT_W,
  parameter int SUM_W     = CS_SUM_W,
  parameter int FAILCNT_W = CS_FAILCNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_bit_valid,
  input  logic                 i_rand,
  output logic                 o_res_valid,
  output logic [SUM_W-2:0]     o_fwd_exc,
  output logic [SUM_W-2:0]     o_bwd_exc,
  output logic                 o_pass_fwd,
  output logic                 o_pass_bwd,
  output logic                 o_pass,
  output logic [FAILCNT_W-1:0] o_block_cnt,
  output logic [FAILCNT_W-1:0] o_fail_cnt
);
  localparam logic signed [SUM_W-1:0] U_S = SUM_W'(U);
  logic [CNT_W-1:0]        r_cnt;
  logic signed [SUM_W-1:0] w_s_nxt, w_smax_nxt, w_smin_nxt, w_fwd, w_bwd;
  logic                    w_last, w_pass_fwd, w_pass_bwd;
  cusum_walk #(.SUM_W(SUM_W)) u_walk (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_last),
    .i_step     (i_bit_valid),
    .i_bit      (i_rand),
    .o_s_nxt    (w_s_nxt),
    .o_smax_nxt (w_smax_nxt),
    .o_smin_nxt (w_smin_nxt)
  );
  // Backward partial sums are S_N - S_k, so the post-step extremes give both modes.
  always_comb begin
    w_last     = i_bit_valid && (r_cnt == CNT_W'(N - 1));
    w_fwd      = (w_smax_nxt > -w_smin_nxt) ? w_smax_nxt : -w_smin_nxt;
    w_bwd      = (w_smax_nxt - w_s_nxt > w_s_nxt - w_smin_nxt) ? w_smax_nxt - w_s_nxt
                                                              : w_s_nxt - w_smin_nxt;
    w_pass_fwd = w_fwd <= U_S;
    w_pass_bwd = w_bwd <= U_S;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || w_last) r_cnt <= '0;
    else if (i_bit_valid) r_cnt <= r_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_res_valid <= 1'b0;
      o_fwd_exc   <= '0;
      o_bwd_exc   <= '0;
      o_pass_fwd  <= 1'b0;
      o_pass_bwd  <= 1'b0;
      o_pass      <= 1'b0;
      o_block_cnt <= '0;
      o_fail_cnt  <= '0;
    end else begin
      o_res_valid <= w_last;
      if (w_last) begin
        o_fwd_exc   <= w_fwd[SUM_W-2:0];
        o_bwd_exc   <= w_bwd[SUM_W-2:0];
        o_pass_fwd  <= w_pass_fwd;
        o_pass_bwd  <= w_pass_bwd;
        o_pass      <= w_pass_fwd && w_pass_bwd;
        o_block_cnt <= o_block_cnt + 1'b1;
        if (!(w_pass_fwd && w_pass_bwd) && o_fail_cnt != '1) o_fail_cnt <= o_fail_cnt + 1'b1;
      end
    end
  end
endmodule
